pixel_clip_fifo: RTL and testbench



---
 rtl/pixel_clip_fifo_if.sv | 35 +++
 rtl/pixel_clip_fifo.sv | 152 +++++++++++++++
 tb/tb_pixel_clip_fifo.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_clip_fifo_if.sv
// -----------------------------------------------------------------------------
// pixel_clip_fifo_if
// Pixel stream bundle between the circle drawer, the clip FIFO and the
// downstream VGA adapter / framebuffer arbiter.
//
//   in_x, in_y, in_colour, in_plot : pixel stream from the drawer (no ready)
//   out_x, out_y, out_colour       : head-of-FIFO pixel
//   out_plot                       : head valid
//   out_ready                      : consumer accepts head this cycle
//
// Modports:
//   master : environment side (drives the in_* stream and out_ready)
//   slave  : FIFO side (consumes in_*, presents out_*)
// -----------------------------------------------------------------------------
interface pixel_clip_fifo_if;
  logic [7:0] in_x;
  logic [6:0] in_y;
  logic [2:0] in_colour;
  logic       in_plot;
  logic [7:0] out_x;
  logic [6:0] out_y;
  logic [2:0] out_colour;
  logic       out_plot;
  logic       out_ready;

  modport master (
    output in_x, in_y, in_colour, in_plot, out_ready,
    input  out_x, out_y, out_colour, out_plot
  );

  modport slave (
    input  in_x, in_y, in_colour, in_plot, out_ready,
    output out_x, out_y, out_colour, out_plot
  );
endinterface

// File: rtl/pixel_clip_fifo.sv
// -----------------------------------------------------------------------------
// pixel_clip_fifo
// Drops drawer pixels that fall outside the SCREEN_W x SCREEN_H screen and
// buffers the in-bounds ones in a DEPTH-entry first-word-fall-through FIFO
// with a valid/ready output handshake.
//
// Ports:
//   clock      : single clock, rising edge
//   reset      : synchronous, active-high
//   bus        : pixel_clip_fifo_if.slave (in_* stream, out_* head, out_ready)
//   flush      : synchronous clear of contents and overflow flag
//   empty      : FIFO holds no pixels
//   count      : occupancy, 0..DEPTH
//   overflow   : sticky, an in-bounds pixel was lost to a full FIFO
//   clip_count : (PIXEL_CLIP_STATS_EN only) out-of-bounds pixels seen
//   drop_count : (PIXEL_CLIP_STATS_EN only) in-bounds pixels lost when full
//
// Optional feature macro: PIXEL_CLIP_STATS_EN adds the two saturating
// 16-bit statistics counters.
// -----------------------------------------------------------------------------
module pixel_clip_fifo #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic                     clock,
  input  logic                     reset,
  pixel_clip_fifo_if.slave         bus,
  input  logic                     flush,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
`ifdef PIXEL_CLIP_STATS_EN
  output logic [15:0]              clip_count,
  output logic [15:0]              drop_count,
`endif
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [2:0] colour;
    logic [6:0] y;
    logic [7:0] x;
  } pixel_t;

  pixel_t          mem [DEPTH];
  pixel_t          head_reg;
  pixel_t          head_next;
  pixel_t          in_pix;
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   rd_ptr_next;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   remain;
  logic            overflow_reg;
  logic            in_bounds;
  logic            full;
  logic            push;
  logic            pop;
  logic            drop;
  logic            clip;

  assign in_pix    = '{colour: bus.in_colour, y: bus.in_y, x: bus.in_x};
  assign in_bounds = (32'(bus.in_x) < SCREEN_W) && (32'(bus.in_y) < SCREEN_H);
  assign full      = (count_reg == CW'(DEPTH));
  assign pop       = bus.out_plot && bus.out_ready;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push      = bus.in_plot && in_bounds && (!full || pop);
  assign drop      = bus.in_plot && in_bounds && full && !pop;
  assign clip      = bus.in_plot && !in_bounds;

  always_comb begin
    count_next  = count_reg + CW'(push) - CW'(pop);
    rd_ptr_next = rd_ptr_reg + AW'(pop);
    remain      = count_reg - CW'(pop);
    // The head register mirrors mem[rd_ptr]. When nothing older survives
    // this edge, the incoming pixel is the new head (it is being written to
    // mem this same edge, so mem cannot supply it yet).
    head_next   = (remain == '0) ? in_pix : mem[rd_ptr_next];
  end

  // Storage: plain array, written at the tail, no reset needed.
  always_ff @(posedge clock) begin
    if (!reset && !flush && push) begin
      mem[wr_ptr_reg] <= in_pix;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      head_reg     <= '0;
    end else if (flush) begin
      // Head fields are don't-care once empty, so they simply hold.
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + AW'(push);
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      if (drop) begin
        overflow_reg <= 1'b1;
      end
      if (count_next != '0) begin
        head_reg <= head_next;
      end
    end
  end

`ifdef PIXEL_CLIP_STATS_EN
  logic [15:0] clip_count_reg;
  logic [15:0] drop_count_reg;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      clip_count_reg <= '0;
      drop_count_reg <= '0;
    end else begin
      if (clip && clip_count_reg != 16'hFFFF) begin
        clip_count_reg <= clip_count_reg + 16'd1;
      end
      if (drop && drop_count_reg != 16'hFFFF) begin
        drop_count_reg <= drop_count_reg + 16'd1;
      end
    end
  end

  assign clip_count = clip_count_reg;
  assign drop_count = drop_count_reg;
`else
  // Keeps the clip decode referenced when the counters are compiled out.
  logic clip_unused;
  assign clip_unused = clip;
`endif

  assign bus.out_x      = head_reg.x;
  assign bus.out_y      = head_reg.y;
  assign bus.out_colour = head_reg.colour;
  assign bus.out_plot   = (count_reg != '0);
  assign empty          = (count_reg == '0);
  assign count          = count_reg;
  assign overflow       = overflow_reg;

endmodule

// File: tb/tb_pixel_clip_fifo.sv
// -----------------------------------------------------------------------------
// tb_pixel_clip_fifo
// Directed bench for pixel_clip_fifo (DEPTH=8, 160x120 screen). Inputs change
// 1 ns after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_pixel_clip_fifo;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        empty;
  logic [3:0]  count;
  logic        overflow;
`ifdef PIXEL_CLIP_STATS_EN
  logic [15:0] clip_count;
  logic [15:0] drop_count;
`endif

  int total;
  int bad;

  pixel_clip_fifo_if bus_if ();

  pixel_clip_fifo #(
    .DEPTH    (8),
    .SCREEN_W (160),
    .SCREEN_H (120)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus_if.slave),
    .flush      (flush),
    .empty      (empty),
    .count      (count),
`ifdef PIXEL_CLIP_STATS_EN
    .clip_count (clip_count),
    .drop_count (drop_count),
`endif
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] x, input logic [6:0] y,
                       input logic [2:0] c, input logic plot);
    bus_if.in_x      = x;
    bus_if.in_y      = y;
    bus_if.in_colour = c;
    bus_if.in_plot   = plot;
  endtask

  task automatic chk_head(input string tag, input logic [7:0] x,
                          input logic [6:0] y, input logic [2:0] c);
    chk({tag, "_plot"}, 32'(bus_if.out_plot), 32'd1);
    chk({tag, "_x"}, 32'(bus_if.out_x), 32'(x));
    chk({tag, "_y"}, 32'(bus_if.out_y), 32'(y));
    chk({tag, "_colour"}, 32'(bus_if.out_colour), 32'(c));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_plot"}, 32'(bus_if.out_plot), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_x"}, 32'(bus_if.out_x), 32'd0);
    chk({tag, "_y"}, 32'(bus_if.out_y), 32'd0);
    chk({tag, "_colour"}, 32'(bus_if.out_colour), 32'd0);
`ifdef PIXEL_CLIP_STATS_EN
    chk({tag, "_clip_count"}, 32'(clip_count), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    flush = 1'b0;
    bus_if.out_ready = 1'b0;
    drive(8'd0, 7'd0, 3'd0, 1'b0);

    // Reset state
    tick();
    tick();
    chk_reset_state("reset");
    reset = 1'b0;
    tick();

    // Basic: push at edge 1, visible after edge 1, popped at edge 2
    bus_if.out_ready = 1'b1;
    drive(8'd80, 7'd60, 3'b011, 1'b1);
    tick();
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk_head("basic", 8'd80, 7'd60, 3'b011);
    chk("basic_count", 32'(count), 32'd1);
    chk("basic_empty0", 32'(empty), 32'd0);
    tick();
    chk("basic_empty1", 32'(empty), 32'd1);
    chk("basic_plot0", 32'(bus_if.out_plot), 32'd0);

    // Clipping: only (159,119) survives
    bus_if.out_ready = 1'b0;
    drive(8'd159, 7'd119, 3'd5, 1'b1); tick();
    drive(8'd160, 7'd60,  3'd1, 1'b1); tick();
    drive(8'd100, 7'd120, 3'd2, 1'b1); tick();
    drive(8'd200, 7'd127, 3'd7, 1'b1); tick();
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk("clip_count_occ", 32'(count), 32'd1);
    chk_head("clip", 8'd159, 7'd119, 3'd5);
    chk("clip_overflow", 32'(overflow), 32'd0);
`ifdef PIXEL_CLIP_STATS_EN
    chk("clip_stat", 32'(clip_count), 32'd3);
`endif
    bus_if.out_ready = 1'b1;
    tick();
    chk("clip_drained", 32'(count), 32'd0);

    // Backpressure: 10 pushes into 8 entries
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(8'(i + 10), 7'(i + 20), 3'(i), 1'b1);
      tick();
      if (i == 7) begin
        chk("bp_full_count", 32'(count), 32'd8);
        chk("bp_full_no_ovf", 32'(overflow), 32'd0);
      end
      if (i == 8) begin
        chk("bp_ovf_set", 32'(overflow), 32'd1);
      end
    end
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk("bp_count", 32'(count), 32'd8);
    chk("bp_overflow", 32'(overflow), 32'd1);
`ifdef PIXEL_CLIP_STATS_EN
    chk("bp_drop_stat", 32'(drop_count), 32'd2);
`endif
    chk_head("bp_hold", 8'd10, 7'd20, 3'd0);
    tick();
    chk_head("bp_hold2", 8'd10, 7'd20, 3'd0);
    bus_if.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk_head("bp_drain", 8'(k + 10), 7'(k + 20), 3'(k));
      tick();
    end
    chk("bp_empty", 32'(empty), 32'd1);
    chk("bp_ovf_sticky", 32'(overflow), 32'd1);

    // Flush clears sticky overflow
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_clears_ovf", 32'(overflow), 32'd0);

    // Full with simultaneous push/pop (pointer wrap)
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(8'(i + 30), 7'(i), 3'(i), 1'b1);
      tick();
    end
    chk("pp_full", 32'(count), 32'd8);
    bus_if.out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk_head("pp_head", 8'(j + 30), 7'(j), 3'(j));
      drive(8'(j + 40), 7'(j + 8), 3'(j + 4), 1'b1);
      tick();
      chk("pp_count", 32'(count), 32'd8);
    end
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk("pp_no_ovf", 32'(overflow), 32'd0);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) chk_head("pp_drain", 8'(k + 34), 7'(k + 4), 3'(k + 4));
      else       chk_head("pp_drain", 8'(k + 36), 7'(k + 4), 3'(k));
      tick();
    end
    chk("pp_empty", 32'(empty), 32'd1);

    // Flush mid-stream with a push in the flush cycle
    bus_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(8'(i + 50), 7'(i), 3'd1, 1'b1);
      tick();
    end
    chk("fl_count5", 32'(count), 32'd5);
    drive(8'd99, 7'd9, 3'd2, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_plot", 32'(bus_if.out_plot), 32'd0);
    chk("fl_empty", 32'(empty), 32'd1);
    chk("fl_overflow", 32'(overflow), 32'd0);
    tick();
    chk("fl_pixel_lost", 32'(count), 32'd0);

    // Reset mid-stream
    for (int i = 0; i < 6; i++) begin
      drive(8'(i + 60), 7'(i), 3'd3, 1'b1);
      tick();
    end
    chk("rs_count6", 32'(count), 32'd6);
    bus_if.out_ready = 1'b1;
    drive(8'd70, 7'd10, 3'd4, 1'b1);
    tick();
    chk("rs_count_pp", 32'(count), 32'd6);
    chk_head("rs_head", 8'd61, 7'd1, 3'd3);
    bus_if.out_ready = 1'b0;
    drive(8'd71, 7'd11, 3'd4, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk_reset_state("rs");
    drive(8'd12, 7'd34, 3'd6, 1'b1);
    tick();
    drive(8'd0, 7'd0, 3'd0, 1'b0);
    chk_head("rs_fresh", 8'd12, 7'd34, 3'd6);
    chk("rs_fresh_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
